// File: rtl/fp_mul_pkg.sv
// Shared constants, flag bundle and FSM state encoding for the shared FP multiplier.
// Imported by the combinational core and by the arbiter top level.
package fp_mul_pkg;

  localparam logic [7:0]  FP_EXP_MAX = 8'd255;
  localparam logic [9:0]  FP_BIAS    = 10'd127;
  localparam logic [31:0] FP_INF     = 32'h7F800000;

  typedef struct packed {
    logic inf;
    logic nan;
    logic zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  typedef logic [1:0] fp_state_t;

  localparam fp_state_t ST_IDLE = 2'd0;
  localparam fp_state_t ST_EXEC = 2'd1;
  localparam fp_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/fp_mul_core.sv
// Combinational single-precision multiply with truncation and a fixed special-case priority.
// Special-case encodings are always positive; exactly one flag (or none) is raised.
module fp_mul_core
  import fp_mul_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] result,
  output logic        inf,
  output logic        nan,
  output logic        zero,
  output logic        overflow,
  output logic        underflow
);

  logic [47:0]       prod_s;
  logic              norm_s;
  logic signed [9:0] exp_s;
  logic [22:0]       mant_s;
  logic              x_max_s;
  logic              y_max_s;

  assign prod_s  = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
  assign norm_s  = prod_s[47];
  assign mant_s  = norm_s ? prod_s[46:24] : prod_s[45:23];
  // Exponent kept 10 bits signed so both underflow (<=0) and overflow (>=255) are visible.
  assign exp_s   = $signed({2'b00, x[30:23]} + {2'b00, y[30:23]} - FP_BIAS + {9'd0, norm_s});
  assign x_max_s = (x[30:23] == FP_EXP_MAX);
  assign y_max_s = (y[30:23] == FP_EXP_MAX);

  // Special-case priority chain: zero, nan, inf, underflow, overflow, normal.
  always_comb begin
    result    = 32'h00000000;
    inf       = 1'b0;
    nan       = 1'b0;
    zero      = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if ((x[30:0] == 31'd0) || (y[30:0] == 31'd0)) begin
      zero = 1'b1;
    end else if ((x_max_s && (x[22:0] != 23'd0)) || (y_max_s && (y[22:0] != 23'd0))) begin
      result = FP_INF;
      nan    = 1'b1;
    end else if (x_max_s || y_max_s) begin
      result = FP_INF;
      inf    = 1'b1;
    end else if (exp_s <= 10'sd0) begin
      underflow = 1'b1;
    end else if (exp_s >= $signed({2'b00, FP_EXP_MAX})) begin
      result   = FP_INF;
      overflow = 1'b1;
    end else begin
      result = {x[31] ^ y[31], exp_s[7:0], mant_s};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that time-shares one fp_mul_core between NUM_REQ requesters.
// One operation in flight: grant in IDLE, compute in EXEC, hold the response in RESP.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_x,
  input  logic [32*NUM_REQ-1:0]   req_y,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             result,
  output logic                    inf,
  output logic                    nan,
  output logic                    zero,
  output logic                    overflow,
  output logic                    underflow
);

  fp_state_t         state_r;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   id_r;
  logic [31:0]       x_r;
  logic [31:0]       y_r;
  fp_flags_t         flags_r;

  logic              hi_found_s;
  logic              lo_found_s;
  logic [ID_W-1:0]   hi_id_s;
  logic [ID_W-1:0]   lo_id_s;
  logic              grant_any_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [ID_W-1:0]   ptr_next_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [31:0]       sel_x_s;
  logic [31:0]       sel_y_s;
  logic [31:0]       core_result_s;
  fp_flags_t         core_flags_s;

  // Round-robin search: first valid at or above the pointer, else the lowest valid overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_id_s    = '0;
    lo_id_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !hi_found_s && (i >= int'(ptr_r))) begin
        hi_found_s = 1'b1;
        hi_id_s    = ID_W'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
      if (req_valid[i] && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_id_s    = ID_W'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    grant_any_s = hi_found_s | lo_found_s;
    grant_id_s  = hi_found_s ? hi_id_s : lo_id_s;
  end

  // One-hot grant vector and operand mux for the winning requester.
  always_comb begin
    grant_s = '0;
    sel_x_s = 32'h00000000;
    sel_y_s = 32'h00000000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any_s && (grant_id_s == ID_W'(i))) begin
        grant_s[i] = 1'b1;
        sel_x_s    = req_x[32*i +: 32];
        sel_y_s    = req_y[32*i +: 32];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign ptr_next_s = (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
  assign req_ready  = ((state_r == ST_IDLE) && !reset) ? grant_s : '0;

  fp_mul_core u_core (
    .x         (x_r),
    .y         (y_r),
    .result    (core_result_s),
    .inf       (core_flags_s.inf),
    .nan       (core_flags_s.nan),
    .zero      (core_flags_s.zero),
    .overflow  (core_flags_s.overflow),
    .underflow (core_flags_s.underflow)
  );

  // Arbiter FSM, operand capture and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      id_r       <= '0;
      x_r        <= 32'h00000000;
      y_r        <= 32'h00000000;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      result     <= 32'h00000000;
      flags_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            x_r     <= sel_x_s;
            y_r     <= sel_y_s;
            id_r    <= grant_id_s;
            ptr_r   <= ptr_next_s;
            state_r <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result     <= core_result_s;
          flags_r    <= core_flags_s;
          resp_id    <= id_r;
          resp_valid <= 1'b1;
          state_r    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r    <= ST_RESP;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign inf       = flags_r.inf;
  assign nan       = flags_r.nan;
  assign zero      = flags_r.zero;
  assign overflow  = flags_r.overflow;
  assign underflow = flags_r.underflow;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: directed and random operations against
// an arithmetic reference model and a round-robin pointer model.
module tb_fp_mul_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_x;
  logic [32*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           result;
  logic                  inf, nan, zero, overflow, underflow;

  logic [31:0] xs [NUM_REQ];
  logic [31:0] ys [NUM_REQ];

  int n_asrt;
  int n_fail;
  int exp_ptr;

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .result     (result),
    .inf        (inf),
    .nan        (nan),
    .zero       (zero),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[32*i +: 32] = xs[i];
      req_y[32*i +: 32] = ys[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REQ; k++) if (k == i) v[k] = 1'b1;
    return v;
  endfunction

  // First valid requester scanning upward from the pointer with wrap-around.
  function automatic int exp_grant(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (((mask >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // Returns {inf, nan, zero, overflow, underflow, result}.
  function automatic logic [36:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int xe, ye, e;
    longint unsigned mx, my, p;
    logic [22:0] m;
    xe = int'(x[30:23]);
    ye = int'(y[30:23]);
    if (x[30:0] == 31'd0 || y[30:0] == 31'd0) return {5'b00100, 32'h00000000};
    if ((xe == 255 && x[22:0] != 23'd0) || (ye == 255 && y[22:0] != 23'd0))
      return {5'b01000, 32'h7F800000};
    if (xe == 255 || ye == 255) return {5'b10000, 32'h7F800000};
    mx = 64'h800000 + 64'(x[22:0]);
    my = 64'h800000 + 64'(y[22:0]);
    p  = mx * my;
    e  = xe + ye - 127;
    if (p >= 64'h0000_8000_0000_0000) begin
      p = p >> 24;
      e = e + 1;
    end else begin
      p = p >> 23;
    end
    m = p[22:0];
    if (e <= 0) return {5'b00001, 32'h00000000};
    if (e >= 255) return {5'b00010, 32'h7F800000};
    return {5'b00000, x[31] ^ y[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_fp;
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(70, 185));
    return v;
  endfunction

  // Check the registered response against the model.
  task automatic chk_resp(input string tag, input logic [36:0] e, input int id);
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_result"}, result, e[31:0]);
    chk({tag, "_flags"}, {inf, nan, zero, overflow, underflow}, e[36:32]);
    chk({tag, "_id"}, resp_id, id);
  endtask

  // Starts in an IDLE cycle, ends in the following IDLE cycle.
  task automatic run_op(input int r, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [36:0] e;
    int g;
    e = ref_mul(x, y);
    xs[r] = x;
    ys[r] = y;
    req_valid = onehot(r);
    resp_ready = 1'b0;
    #1;
    g = exp_grant(req_valid, exp_ptr);
    chk("grant", req_ready, onehot(g));
    exp_ptr = (g + 1) % NUM_REQ;
    tick;
    req_valid = '0;
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_valid", resp_valid, 0);
    tick;
    req_valid = '1;
    #1;
    chk("resp_ready_blocked", req_ready, 0);
    chk_resp("resp", e, g);
    for (int h = 0; h < hold; h++) begin
      tick;
      #1;
      chk("hold_ready", req_ready, 0);
      chk_resp("hold", e, g);
    end
    req_valid = '0;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    #1;
    chk("released", resp_valid, 0);
  endtask

  initial begin
    logic [36:0] e;
    int g;
    n_asrt = 0;
    n_fail = 0;
    exp_ptr = 0;
    reset = 1'b1;
    req_valid = '1;
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      xs[i] = 32'h3F800000;
      ys[i] = 32'h3F800000;
    end
    tick;
    #1;
    chk("reset_ready", req_ready, 0);
    tick;
    req_valid = '0;
    reset = 1'b0;
    #1;
    chk("reset_valid", resp_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {inf, nan, zero, overflow, underflow}, 0);
    chk("reset_id", resp_id, 0);
    chk("idle_no_req", req_ready, 0);

    // Directed arithmetic cases.
    run_op(0, 32'h40000000, 32'h40400000, 0);
    run_op(1, 32'h3FC00000, 32'h3FC00000, 0);
    run_op(0, 32'h00000000, 32'h40000000, 0);
    run_op(1, 32'h7FC00000, 32'h3F800000, 1);
    run_op(0, 32'h7F800000, 32'h3F800000, 0);
    run_op(1, 32'h7F000000, 32'h7F000000, 0);
    run_op(0, 32'h00800000, 32'h00800000, 0);
    run_op(1, 32'hC0000000, 32'h40400000, 0);

    // Backpressure for 5 cycles; waiting requests are granted right after release.
    xs[0] = 32'h40A00000; ys[0] = 32'h3F000000;
    xs[1] = 32'h41200000; ys[1] = 32'h40000000;
    req_valid = '1;
    resp_ready = 1'b0;
    #1;
    g = exp_grant(req_valid, exp_ptr);
    chk("bp_grant", req_ready, onehot(g));
    exp_ptr = (g + 1) % NUM_REQ;
    e = ref_mul(xs[g], ys[g]);
    tick;
    tick;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      chk_resp("bp", e, g);
      tick;
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    #1;
    chk("bp_released", resp_valid, 0);
    g = exp_grant(req_valid, exp_ptr);
    chk("bp_next_grant", req_ready, onehot(g));
    exp_ptr = (g + 1) % NUM_REQ;
    e = ref_mul(xs[g], ys[g]);
    tick;
    tick;
    resp_ready = 1'b1;
    #1;
    chk_resp("bp_next", e, g);
    tick;

    // Both requesters continuously valid: alternating grants every 3 cycles.
    for (int it = 0; it < 6; it++) begin
      #1;
      g = exp_grant(req_valid, exp_ptr);
      chk("rr_grant", req_ready, onehot(g));
      exp_ptr = (g + 1) % NUM_REQ;
      e = ref_mul(xs[g], ys[g]);
      tick;
      chk("rr_exec", req_ready, 0);
      tick;
      chk_resp("rr", e, g);
      tick;
    end
    req_valid = '0;
    resp_ready = 1'b0;

    // Reset in EXEC drops the operation and clears the pointer.
    run_op(1, 32'h40000000, 32'h40000000, 0);
    xs[0] = 32'h40400000; ys[0] = 32'h40400000;
    req_valid = onehot(0);
    #1;
    g = exp_grant(req_valid, exp_ptr);
    chk("rst_pre_grant", req_ready, onehot(g));
    tick;
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_exec_ready", req_ready, 0);
    tick;
    reset = 1'b0;
    exp_ptr = 0;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {inf, nan, zero, overflow, underflow}, 0);
    chk("rst_id", resp_id, 0);
    for (int h = 0; h < 3; h++) begin
      tick;
      #1;
      chk("rst_no_resp", resp_valid, 0);
    end
    run_op(1, 32'h3F800000, 32'h3F800000, 0);
    req_valid = '1;
    #1;
    chk("rst_ptr_grant", req_ready, onehot(exp_grant(req_valid, 0)));
    req_valid = '0;
    tick;
    tick;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    exp_ptr = 1;

    // Random operations with random requester and backpressure.
    for (int n = 0; n < 24; n++) begin
      run_op(int'($urandom_range(0, NUM_REQ - 1)), rand_fp(), rand_fp(), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one single-precision floating-point multiplier between NUM_REQ requesters using round-robin arbitration.
- Accepts one operand pair per grant, registers it, and computes the product in a one-cycle execute state.
- Returns result, IEEE-style status flags and the requester ID on a shared response channel with backpressure.
- Sits between the lab's compute clients and the FP multiply datapath, so that only one multiplier is instantiated.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the requester ID; must equal clog2(NUM_REQ) (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_x  in  32*NUM_REQ  operand X per requester; requester i occupies bits [32i+31:32i].
- req_y  in  32*NUM_REQ  operand Y per requester; same packing as req_x.
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
- resp_valid  out  1  response holds valid data.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  index of the requester that owns the response.
- result  out  32  product or special-case encoding.
- inf, nan, zero, overflow, underflow  out  1 each  status flags; at most one is high.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (synchronous, from any state):
  - state goes to IDLE and the round-robin pointer goes to 0.
  - resp_valid, resp_id, result and all flags clear to 0.
  - req_ready is 0 during the reset cycle.
  - Any in-flight operation is dropped and no response is produced for it.
- IDLE:
  - req_ready is combinational and one-hot: it selects the first requester with req_valid set, searching from the pointer upward with wrap-around.
  - If no requester is valid, req_ready is all zero.
  - On a transfer: latch X, Y and the ID; set the pointer to (granted ID + 1) mod NUM_REQ; go to EXEC.
  - req_ready is 0 in every other state.
- EXEC (exactly one cycle):
  - The core computes on the latched operands.
  - result, flags and resp_id are registered.
  - Next state is RESP.
- RESP:
  - resp_valid=1; result, flags and resp_id are held stable.
  - When resp_ready=1, go to IDLE and drop resp_valid in the next cycle.
- Timing:
  - Latency from the grant cycle to the first resp_valid cycle is 2 cycles.
  - Maximum throughput is 1 operation per 3 cycles.
- Arithmetic (core, combinational):
  - sign = Xs ^ Ys.
  - Mantissa product = {1,Xm} * {1,Ym}, 48 bits.
  - If bit 47 is set, mantissa = p[46:24] and exponent += 1; otherwise mantissa = p[45:23].
  - Truncate; no rounding.
  - Exponent is computed signed, 10 bits wide: e = Xe + Ye - 127 (+1 when normalising).
- Special-case priority (first match wins):
  1. zero: X[30:0]==0 or Y[30:0]==0. Result 0x00000000, zero=1.
  2. nan: either operand has exponent 255 and a nonzero mantissa. Result 0x7F800000, nan=1.
  3. inf: either operand has exponent 255 and a zero mantissa. Result 0x7F800000, inf=1.
  4. underflow: e <= 0. Result 0x00000000, underflow=1.
  5. overflow: e >= 255. Result 0x7F800000, overflow=1.
  6. Otherwise: result = {sign, e[7:0], mantissa}; all flags are 0.
- Special-case results are always positive (sign bit 0).
- Boundary conditions:
  - req_valid may drop while not granted; no state change results.
  - Requests arriving during EXEC or RESP wait in their requester's hold; they are not lost.
  - With NUM_REQ=1 the arbiter degenerates to a pass-through grant.

Decomposition:
- Package fp_mul_pkg:
  - FP_EXP_MAX=255, FP_BIAS=127, FP_INF=32'h7F800000.
  - Struct fp_flags_t {inf, nan, zero, overflow, underflow}.
  - State enum.
- Sub-module fp_mul_core: purely combinational. Ports X, Y, result, and the five flags; implements the arithmetic and priority above.
- Arbiter FSM, round-robin pointer and registers live in fp_mul_arbiter.

Test Plan:
- Requester 0 sends 0x40000000 * 0x40400000 → after 2 cycles resp_valid=1, result=0x40C00000, resp_id=0, all flags 0. Requester 1 sends 0x3FC00000 * 0x3FC00000 → result=0x40100000.
- 0x00000000 * 0x40000000 → result 0, zero=1. 0x7FC00000 * 0x3F800000 → 0x7F800000, nan=1. 0x7F800000 * 0x3F800000 → 0x7F800000, inf=1.
- 0x7F000000 * 0x7F000000 → 0x7F800000, overflow=1. 0x00800000 * 0x00800000 → 0x00000000, underflow=1.
- Both requesters hold req_valid continuously with resp_ready=1 → grants alternate 0,1,0,1, one every 3 cycles, and resp_id matches each grant.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and result stay stable, req_ready stays 0, and the next grant follows one cycle after resp_ready rises.
- Assert reset during EXEC → next cycle is IDLE with pointer 0 and all outputs 0, and no response is produced for the dropped operation.
